// File: rtl/control_unit_pkg.sv
// Shared opcodes, FSM state encoding, instruction classes and ALU function codes
// for the multicycle control unit.
package cpu_ctrl_pkg;

   localparam int OPC_W   = 5;
   localparam int ALUOP_W = 4;

   localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
   localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
   localparam logic [OPC_W-1:0] OP_IN   = 5'b10101;
   localparam logic [OPC_W-1:0] OP_OUT  = 5'b10110;
   localparam logic [OPC_W-1:0] OP_MFHI = 5'b10111;
   localparam logic [OPC_W-1:0] OP_MFLO = 5'b11000;
   localparam logic [OPC_W-1:0] OP_NOP  = 5'b11001;
   localparam logic [OPC_W-1:0] OP_HALT = 5'b11010;

   localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'h0;
   localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'h1;
   localparam logic [ALUOP_W-1:0] ALU_AND  = 4'h2;
   localparam logic [ALUOP_W-1:0] ALU_OR   = 4'h3;
   localparam logic [ALUOP_W-1:0] ALU_PASS = 4'hF;

   typedef enum logic [3:0] {
      RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
   } state_t;

   typedef enum logic [3:0] {
      CLS_LD, CLS_LDI, CLS_ST, CLS_ALU_R, CLS_ALU_I,
      CLS_MOVE, CLS_IO, CLS_NOP, CLS_HALT, CLS_ILLEGAL
   } instr_class_t;

endpackage

// File: rtl/control_unit_opcode_decode.sv
// Combinational opcode classifier: instruction class plus the ALU function used
// in that class's T4 step (address add for memory ops).
module ctrl_opcode_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [OPC_W-1:0]   opcode,
   output instr_class_t       cls,
   output logic [ALUOP_W-1:0] alu_op
);

   always_comb begin
      cls    = CLS_ILLEGAL;
      alu_op = ALU_PASS;
      case (opcode)
         OP_LD:   begin cls = CLS_LD;    alu_op = ALU_ADD; end
         OP_LDI:  begin cls = CLS_LDI;   alu_op = ALU_ADD; end
         OP_ST:   begin cls = CLS_ST;    alu_op = ALU_ADD; end
         OP_ADD:  begin cls = CLS_ALU_R; alu_op = ALU_ADD; end
         OP_SUB:  begin cls = CLS_ALU_R; alu_op = ALU_SUB; end
         OP_AND:  begin cls = CLS_ALU_R; alu_op = ALU_AND; end
         OP_OR:   begin cls = CLS_ALU_R; alu_op = ALU_OR;  end
         OP_ADDI: begin cls = CLS_ALU_I; alu_op = ALU_ADD; end
         OP_ANDI: begin cls = CLS_ALU_I; alu_op = ALU_AND; end
         OP_ORI:  begin cls = CLS_ALU_I; alu_op = ALU_OR;  end
         OP_MFHI, OP_MFLO: cls = CLS_MOVE;
         OP_IN, OP_OUT:    cls = CLS_IO;
         OP_NOP:           cls = CLS_NOP;
         OP_HALT:          cls = CLS_HALT;
         default:          cls = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multicycle Moore control FSM sequencing the Datapath through fetch, decode and
// execute; all strobes are a function of state and the IR opcode only.
module control_unit
   import cpu_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                clr,
   input  logic [31:0]         ir,
   input  logic                con_ff,
   output logic                pc_out,
   output logic                zlo_out,
   output logic                zhi_out,
   output logic                hi_out,
   output logic                lo_out,
   output logic                mdr_out,
   output logic                inport_out,
   output logic                c_sign_extended_out,
   output logic                ba_out,
   output logic                mar_enable,
   output logic                z_enable,
   output logic                pc_enable,
   output logic                mdr_enable,
   output logic                ir_enable,
   output logic                y_enable,
   output logic                hi_enable,
   output logic                lo_enable,
   output logic                outport_enable,
   output logic                con_enable,
   output logic                pc_increment,
   output logic                read,
   output logic                ram_write,
   output logic                gra,
   output logic                grb,
   output logic                grc,
   output logic                r_in,
   output logic                r_out,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                run,
   output logic                illegal_op
);

   state_t               state;
   state_t               next_state;
   instr_class_t         cls;
   logic [ALUOP_W-1:0]   dec_alu_op;
   logic [OPC_W-1:0]     opcode;
   logic                 unused_inputs;

   assign opcode        = ir[31:27];
   assign unused_inputs = ^{con_ff, ir[26:0]};

   ctrl_opcode_decode u_decode (
      .opcode (opcode),
      .cls    (cls),
      .alu_op (dec_alu_op)
   );

   always_ff @(posedge clk) begin
      if (!clr) state <= RESET;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         RESET: next_state = T0;
         T0:    next_state = T1;
         T1:    next_state = T2;
         T2:    next_state = T3;
         T3: begin
            case (cls)
               CLS_LD, CLS_LDI, CLS_ST, CLS_ALU_R, CLS_ALU_I: next_state = T4;
               CLS_HALT: next_state = HALT;
               default:  next_state = T0;
            endcase
         end
         T4:    next_state = T5;
         T5:    next_state = (cls == CLS_LD || cls == CLS_ST) ? T6 : T0;
         T6:    next_state = T7;
         T7:    next_state = T0;
         HALT:  next_state = HALT;
         default: next_state = RESET;
      endcase
   end

   // Later steps re-decode the held IR, so T4..T7 still know the instruction class.
   always_comb begin
      pc_out = 1'b0; zlo_out = 1'b0; zhi_out = 1'b0; hi_out = 1'b0; lo_out = 1'b0;
      mdr_out = 1'b0; inport_out = 1'b0; c_sign_extended_out = 1'b0; ba_out = 1'b0;
      mar_enable = 1'b0; z_enable = 1'b0; pc_enable = 1'b0; mdr_enable = 1'b0;
      ir_enable = 1'b0; y_enable = 1'b0; hi_enable = 1'b0; lo_enable = 1'b0;
      outport_enable = 1'b0; con_enable = 1'b0; pc_increment = 1'b0; read = 1'b0;
      ram_write = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0;
      alu_op = ALU_PASS;
      illegal_op = 1'b0;
      run = (state != RESET) && (state != HALT);
      case (state)
         T0: begin
            pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; z_enable = 1'b1;
            alu_op = ALU_ADD;
         end
         T1: begin
            zlo_out = 1'b1; pc_enable = 1'b1; read = 1'b1; mdr_enable = 1'b1;
         end
         T2: begin
            mdr_out = 1'b1; ir_enable = 1'b1;
         end
         T3: begin
            case (cls)
               CLS_LD, CLS_LDI, CLS_ST: begin grb = 1'b1; ba_out = 1'b1; y_enable = 1'b1; end
               CLS_ALU_R, CLS_ALU_I:    begin grb = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
               CLS_MOVE: begin
                  hi_out = (opcode == OP_MFHI);
                  lo_out = (opcode != OP_MFHI);
                  gra = 1'b1; r_in = 1'b1;
               end
               CLS_IO: begin
                  gra = 1'b1;
                  if (opcode == OP_IN) begin inport_out = 1'b1; r_in = 1'b1; end
                  else begin r_out = 1'b1; outport_enable = 1'b1; end
               end
               CLS_ILLEGAL: illegal_op = 1'b1;
               default: ;
            endcase
         end
         T4: begin
            z_enable = 1'b1;
            alu_op   = dec_alu_op;
            if (cls == CLS_ALU_R) begin grc = 1'b1; r_out = 1'b1; end
            else c_sign_extended_out = 1'b1;
         end
         T5: begin
            zlo_out = 1'b1;
            if (cls == CLS_LD || cls == CLS_ST) mar_enable = 1'b1;
            else begin gra = 1'b1; r_in = 1'b1; end
         end
         T6: begin
            mdr_enable = 1'b1;
            if (cls == CLS_ST) begin gra = 1'b1; r_out = 1'b1; end
            else read = 1'b1;
         end
         T7: begin
            if (cls == CLS_ST) ram_write = 1'b1;
            else begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: drives IR opcodes and checks
// every strobe, alu_op, run and illegal_op per FSM step against hand-built vectors.
module tb_control_unit;

   logic clk, clr, con_ff;
   logic [31:0] ir;
   logic pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out;
   logic c_sign_extended_out, ba_out, mar_enable, z_enable, pc_enable, mdr_enable;
   logic ir_enable, y_enable, hi_enable, lo_enable, outport_enable, con_enable;
   logic pc_increment, read, ram_write, gra, grb, grc, r_in, r_out;
   logic [3:0] alu_op;
   logic run, illegal_op;
   logic [26:0] strobes;

   int checks = 0;
   int failures = 0;

   localparam logic [26:0] PC_OUT = 27'd1 << 26, ZLO_OUT = 27'd1 << 25, ZHI_OUT = 27'd1 << 24;
   localparam logic [26:0] HI_OUT = 27'd1 << 23, LO_OUT = 27'd1 << 22, MDR_OUT = 27'd1 << 21;
   localparam logic [26:0] IN_OUT = 27'd1 << 20, CSE_OUT = 27'd1 << 19, BA_OUT = 27'd1 << 18;
   localparam logic [26:0] MAR_EN = 27'd1 << 17, Z_EN = 27'd1 << 16, PC_EN = 27'd1 << 15;
   localparam logic [26:0] MDR_EN = 27'd1 << 14, IR_EN = 27'd1 << 13, Y_EN = 27'd1 << 12;
   localparam logic [26:0] HI_EN = 27'd1 << 11, LO_EN = 27'd1 << 10, OUTP_EN = 27'd1 << 9;
   localparam logic [26:0] CON_EN = 27'd1 << 8, PC_INC = 27'd1 << 7, READ = 27'd1 << 6;
   localparam logic [26:0] RAM_WR = 27'd1 << 5, GRA = 27'd1 << 4, GRB = 27'd1 << 3;
   localparam logic [26:0] GRC = 27'd1 << 2, R_IN = 27'd1 << 1, R_OUT = 27'd1 << 0;
   localparam logic [26:0] NONE = 27'd0;
   localparam logic [3:0]  PASS = 4'hF;

   assign strobes = {pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out,
                     c_sign_extended_out, ba_out, mar_enable, z_enable, pc_enable,
                     mdr_enable, ir_enable, y_enable, hi_enable, lo_enable,
                     outport_enable, con_enable, pc_increment, read, ram_write,
                     gra, grb, grc, r_in, r_out};

   control_unit dut (
      .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff),
      .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .hi_out(hi_out),
      .lo_out(lo_out), .mdr_out(mdr_out), .inport_out(inport_out),
      .c_sign_extended_out(c_sign_extended_out), .ba_out(ba_out),
      .mar_enable(mar_enable), .z_enable(z_enable), .pc_enable(pc_enable),
      .mdr_enable(mdr_enable), .ir_enable(ir_enable), .y_enable(y_enable),
      .hi_enable(hi_enable), .lo_enable(lo_enable), .outport_enable(outport_enable),
      .con_enable(con_enable), .pc_increment(pc_increment), .read(read),
      .ram_write(ram_write), .gra(gra), .grb(grb), .grc(grc), .r_in(r_in),
      .r_out(r_out), .alu_op(alu_op), .run(run), .illegal_op(illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic check_output(input string tag, input logic [26:0] exp_strobes,
                               input logic [3:0] exp_alu, input logic exp_run,
                               input logic exp_ill);
      checks++;
      assert ({strobes, alu_op, run, illegal_op} === {exp_strobes, exp_alu, exp_run, exp_ill})
      else begin
         failures++;
         $error("FAIL %s observed strobes=%h alu=%h run=%b ill=%b expected strobes=%h alu=%h run=%b ill=%b",
                tag, strobes, alu_op, run, illegal_op, exp_strobes, exp_alu, exp_run, exp_ill);
      end
   endtask

   // Called in T0 at a falling edge; checks T0..T2 and leaves the bench in T3.
   task automatic do_fetch(input string tag, input logic [4:0] opc);
      ir = {opc, 27'h0123456};
      check_output({tag, " T0"}, PC_OUT | MAR_EN | PC_INC | Z_EN, 4'h0, 1'b1, 1'b0);
      tick();
      check_output({tag, " T1"}, ZLO_OUT | PC_EN | READ | MDR_EN, PASS, 1'b1, 1'b0);
      tick();
      check_output({tag, " T2"}, MDR_OUT | IR_EN, PASS, 1'b1, 1'b0);
      tick();
   endtask

   initial begin
      clr = 1'b0;
      con_ff = 1'b0;
      ir = 32'h0;
      tick();
      check_output("reset c1", NONE, PASS, 1'b0, 1'b0);
      tick();
      check_output("reset c2", NONE, PASS, 1'b0, 1'b0);
      clr = 1'b1;
      tick();

      // st: 8 cycles, single ram_write in T7
      do_fetch("st", 5'b00010);
      check_output("st T3", GRB | BA_OUT | Y_EN, PASS, 1'b1, 1'b0); tick();
      check_output("st T4", CSE_OUT | Z_EN, 4'h0, 1'b1, 1'b0); tick();
      check_output("st T5", ZLO_OUT | MAR_EN, PASS, 1'b1, 1'b0); tick();
      check_output("st T6", GRA | R_OUT | MDR_EN, PASS, 1'b1, 1'b0); tick();
      check_output("st T7", RAM_WR, PASS, 1'b1, 1'b0); tick();

      do_fetch("add", 5'b00011);
      check_output("add T3", GRB | R_OUT | Y_EN, PASS, 1'b1, 1'b0); tick();
      check_output("add T4", GRC | R_OUT | Z_EN, 4'h0, 1'b1, 1'b0); tick();
      check_output("add T5", ZLO_OUT | GRA | R_IN, PASS, 1'b1, 1'b0); tick();

      do_fetch("ori", 5'b01110);
      check_output("ori T3", GRB | R_OUT | Y_EN, PASS, 1'b1, 1'b0); tick();
      check_output("ori T4", CSE_OUT | Z_EN, 4'h3, 1'b1, 1'b0); tick();
      check_output("ori T5", ZLO_OUT | GRA | R_IN, PASS, 1'b1, 1'b0); tick();

      do_fetch("sub", 5'b00100);
      tick();
      check_output("sub T4", GRC | R_OUT | Z_EN, 4'h1, 1'b1, 1'b0); tick();
      tick();

      do_fetch("ld", 5'b00000);
      check_output("ld T3", GRB | BA_OUT | Y_EN, PASS, 1'b1, 1'b0); tick();
      check_output("ld T4", CSE_OUT | Z_EN, 4'h0, 1'b1, 1'b0); tick();
      check_output("ld T5", ZLO_OUT | MAR_EN, PASS, 1'b1, 1'b0); tick();
      check_output("ld T6", READ | MDR_EN, PASS, 1'b1, 1'b0); tick();
      check_output("ld T7", MDR_OUT | GRA | R_IN, PASS, 1'b1, 1'b0); tick();

      do_fetch("ldi", 5'b00001);
      tick(); tick();
      check_output("ldi T5", ZLO_OUT | GRA | R_IN, PASS, 1'b1, 1'b0); tick();

      do_fetch("mfhi", 5'b10111);
      check_output("mfhi T3", HI_OUT | GRA | R_IN, PASS, 1'b1, 1'b0); tick();
      do_fetch("mflo", 5'b11000);
      check_output("mflo T3", LO_OUT | GRA | R_IN, PASS, 1'b1, 1'b0); tick();
      do_fetch("in", 5'b10101);
      check_output("in T3", IN_OUT | GRA | R_IN, PASS, 1'b1, 1'b0); tick();
      do_fetch("out", 5'b10110);
      check_output("out T3", GRA | R_OUT | OUTP_EN, PASS, 1'b1, 1'b0); tick();
      do_fetch("nop", 5'b11001);
      check_output("nop T3", NONE, PASS, 1'b1, 1'b0); tick();

      do_fetch("illegal", 5'b11111);
      check_output("illegal T3", NONE, PASS, 1'b1, 1'b1); tick();
      check_output("illegal next T0", PC_OUT | MAR_EN | PC_INC | Z_EN, 4'h0, 1'b1, 1'b0);

      do_fetch("halt", 5'b11010);
      check_output("halt T3", NONE, PASS, 1'b1, 1'b0); tick();
      for (int i = 0; i < 20; i++) begin
         check_output("halt hold", NONE, PASS, 1'b0, 1'b0);
         tick();
      end
      clr = 1'b0;
      tick();
      check_output("halt clr", NONE, PASS, 1'b0, 1'b0);
      clr = 1'b1;
      tick();

      // reset during st T6 aborts before the write
      do_fetch("st abort", 5'b00010);
      tick(); tick(); tick();
      check_output("st abort T6", GRA | R_OUT | MDR_EN, PASS, 1'b1, 1'b0);
      clr = 1'b0;
      tick();
      check_output("st abort reset", NONE, PASS, 1'b0, 1'b0);
      clr = 1'b1;
      tick();
      check_output("st abort T0", PC_OUT | MAR_EN | PC_INC | Z_EN, 4'h0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
